mem_access_stage_p: RTL and testbench
=====================================

// Module: mem_access_stage_p
// PURPOSE
//  Parametrised MEM pipeline stage: internal byte-addressed data memory with byte/half/word loads and stores,
//  sign/zero load extension, configurable memory wait states with stall handshake, misalignment trap, and a
//  debug read port. Sits between EX/MEM and WB; feeds a registered MEM/WB bundle to write-back.
// PARAMETERS
//  DATA_W      32    datapath width, fixed at 32 (byte lanes = 4)
//  ADDR_W      32    address width of in_addr / dbg_addr
//  MEM_WORDS   1024  memory depth in words (power of 2); index = addr[log2(MEM_WORDS)+1:2], upper bits ignored (wrap)
//  WB_W        5     width of pass-through write-back control bundle
//  MEM_LAT     0     wait cycles per load/store (0..7); access occupies MEM_LAT+1 cycles
// PORTS
//  clk         in   1       clock, all state on rising edge
//  rst         in   1       asynchronous, active-low reset
//  in_wb       in   WB_W    write-back control from EX/MEM
//  in_rd       in   1       load request
//  in_wr       in   1       store request (in_rd&in_wr both high: treated as store)
//  in_size     in   2       00 byte, 01 half, 10 word, 11 = word
//  in_uns      in   1       1 = zero-extend load, 0 = sign-extend
//  in_addr     in   ADDR_W  byte address (ALU result)
//  in_wdata    in   32      store data (low bytes used for b/h)
//  in_wreg     in   5       destination register index
//  stop_debug  in   1       freeze: all registers, FSM and memory hold
//  dbg_on      in   1       debug mode: memory port owned by debug reads
//  dbg_addr    in   ADDR_W  debug byte address (word-aligned use)
//  stall       out  1       combinational: upstream must hold inputs, EX/MEM must not advance
//  misalign    out  1       registered one-cycle pulse on misaligned access
//  out_wb      out  WB_W    MEM/WB write-back control
//  out_rdata   out  32      MEM/WB extended load data
//  out_alu     out  ADDR_W  MEM/WB copy of in_addr
//  out_wreg    out  5       MEM/WB destination index
//  out_dbg     out  32      registered debug read word
// BEHAVIOUR
//  Reset (rst=0, any time, async): all outputs 0, FSM IDLE, wait counter 0; memory contents NOT cleared.
//  access = (in_rd|in_wr) & !dbg_on. Misaligned: half with addr[0]=1, word with addr[1:0]!=0.
//  FSM IDLE/WAIT. MEM_LAT=0: access completes in the cycle presented, stall never asserted.
//  MEM_LAT>0: IDLE with aligned access -> WAIT, cnt=1, stall=1; WAIT: stall=1 while cnt<MEM_LAT, cnt++;
//   cnt==MEM_LAT: stall=0, completion edge, ->IDLE. Load data visible MEM_LAT+1 edges after request.
//  Completion edge: store writes enabled byte lanes (little-endian, lane = addr[1:0]); load latches extended data
//   into out_rdata; out_wb/out_alu/out_wreg capture inputs.
//  Stall cycles: MEM/WB captures a bubble (out_wb=0, others hold) so WB never repeats a write.
//  Non-access cycles: MEM/WB captures inputs directly, out_rdata holds.
//  Misaligned access: no FSM wait, no memory write; misalign=1 for one cycle, out_wb=0 bubble.
//  dbg_on=1: pipeline accesses ignored (no write, no stall); out_dbg <= mem[dbg_addr] each edge; MEM/WB captures
//   inputs with out_wb=0. dbg_on rising during WAIT: current access completes first, then debug owns port.
//  stop_debug=1: nothing updates (incl. cnt, misalign held at current value); stall keeps its current value.
//  Extension: byte -> bits[7] replicated or zero; half -> bit[15] replicated or zero; word unchanged.
// TESTING
//  1 Reset: drive rst=0 mid-operation -> all outputs 0 immediately, stall=0, FSM IDLE after release.
//  2 MEM_LAT=0: sb 0x80 @0x3, then lb @0x3 -> out_rdata=0xFFFFFF80; lbu @0x3 -> 0x00000080; other lanes of word 0 unchanged.
//  3 sw 0x12345678 @0x8, lh @0xA -> 0x00001234; lhu @0x8 -> 0x00005678; lw @0x8 -> 0x12345678.
//  4 MEM_LAT=2: lw @0x8 -> stall=1 for 2 cycles, out_wb=0 on those edges, data+out_wb on 3rd edge; back-to-back loads each take 3 cycles.
//  5 lw @0x6 (misaligned) -> misalign pulse 1 cycle, out_wb=0, no stall; sh @0x1 -> memory unchanged.
//  6 stop_debug=1 for 3 cycles during WAIT -> outputs and cnt frozen, completion delayed 3 cycles; dbg_on with dbg_addr=0x8 -> out_dbg=0x12345678 next edge, no pipeline write.

Source files
------------

// File: rtl/mem_access_stage_p.sv
// MEM pipeline stage: byte-addressed data memory, sized and extended loads,
// byte-lane stores, wait-state stall handshake, misalign trap and debug read.
module mem_access_stage_p #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int MEM_WORDS = 1024,
    parameter int WB_W      = 5,
    parameter int MEM_LAT   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WB_W-1:0]   in_wb,
    input  logic              in_rd,
    input  logic              in_wr,
    input  logic [1:0]        in_size,
    input  logic              in_uns,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_wdata,
    input  logic [4:0]        in_wreg,
    input  logic              stop_debug,
    input  logic              dbg_on,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic              stall,
    output logic              misalign,
    output logic [WB_W-1:0]   out_wb,
    output logic [DATA_W-1:0] out_rdata,
    output logic [ADDR_W-1:0] out_alu,
    output logic [4:0]        out_wreg,
    output logic [DATA_W-1:0] out_dbg
);

    localparam int IW = $clog2(MEM_WORDS);
    localparam logic [2:0] LAT = 3'(MEM_LAT);
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    logic [0:0]        state;
    logic [2:0]        cnt;
    logic [31:0]       mem [MEM_WORDS];
    logic [IW-1:0]     idx;
    logic [IW-1:0]     dbgIdx;
    logic              access;
    logic              misAl;
    logic              inWait;
    logic              good;
    logic              done;
    logic              isLoad;
    logic              wrEn;
    logic [3:0]        be;
    logic [31:0]       wrData;
    logic [31:0]       rword;
    logic [7:0]        rbyte;
    logic [15:0]       rhalf;
    logic [31:0]       ldData;
    logic              unusedBits;

    assign idx    = in_addr[IW+1:2];
    assign dbgIdx = dbg_addr[IW+1:2];
    assign unusedBits = ^dbg_addr;

    assign access = (in_rd | in_wr) & ~dbg_on;
    assign misAl  = access &
                    (((in_size == 2'b01) & in_addr[0]) |
                     (in_size[1] & (in_addr[1:0] != 2'b00)));
    assign inWait = (state == ST_WAIT);
    assign good   = access & ~misAl & ~inWait;
    assign isLoad = in_rd & ~in_wr;
    assign wrEn   = done & in_wr & ~stop_debug;

    // completion point: same cycle without wait states, else last WAIT cycle
    always_comb begin
        done  = 1'b0;
        stall = 1'b0;
        if (MEM_LAT == 0) begin
            done = good;
        end else begin
            done  = inWait && (cnt == LAT);
            stall = rst && (good || (inWait && (cnt != LAT)));
        end
    end

    // store lane enables and lane-replicated write data
    always_comb begin
        be     = 4'b1111;
        wrData = in_wdata;
        unique case (1'b1)
            (in_size == 2'b00): begin
                be     = 4'b0001 << in_addr[1:0];
                wrData = {4{in_wdata[7:0]}};
            end
            (in_size == 2'b01): begin
                be     = in_addr[1] ? 4'b1100 : 4'b0011;
                wrData = {2{in_wdata[15:0]}};
            end
            in_size[1]: begin
                be     = 4'b1111;
                wrData = in_wdata;
            end
        endcase
    end

    // load lane selection and sign/zero extension
    always_comb begin
        rword  = mem[idx];
        rbyte  = rword[{in_addr[1:0], 3'b000} +: 8];
        rhalf  = in_addr[1] ? rword[31:16] : rword[15:0];
        ldData = rword;
        unique case (1'b1)
            (in_size == 2'b00):
                ldData = in_uns ? {24'b0, rbyte}
                                : {{24{rbyte[7]}}, rbyte};
            (in_size == 2'b01):
                ldData = in_uns ? {16'b0, rhalf}
                                : {{16{rhalf[15]}}, rhalf};
            in_size[1]:
                ldData = rword;
        endcase
    end

    // data memory array; contents survive reset
    always_ff @(posedge clk) begin
        if (wrEn) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[idx][8*b +: 8] <= wrData[8*b +: 8];
            end
        end
    end

    // wait-state FSM
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            cnt   <= 3'd0;
        end else if (!stop_debug && (MEM_LAT != 0)) begin
            if (!inWait) begin
                if (good) begin
                    state <= ST_WAIT;
                    cnt   <= 3'd1;
                end
            end else if (cnt != LAT) begin
                cnt <= cnt + 3'd1;
            end else begin
                state <= ST_IDLE;
                cnt   <= 3'd0;
            end
        end
    end

    // MEM/WB register, bubble insertion and debug read word
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            misalign  <= 1'b0;
            out_wb    <= '0;
            out_rdata <= '0;
            out_alu   <= '0;
            out_wreg  <= '0;
            out_dbg   <= '0;
        end else if (!stop_debug) begin
            misalign <= misAl & ~inWait;
            if (done) begin
                out_wb   <= in_wb;
                out_alu  <= in_addr;
                out_wreg <= in_wreg;
                if (isLoad) out_rdata <= ldData;
            end else if (stall) begin
                out_wb <= '0;
            end else begin
                out_wb   <= (misAl | dbg_on) ? '0 : in_wb;
                out_alu  <= in_addr;
                out_wreg <= in_wreg;
            end
            if (dbg_on) out_dbg <= mem[dbgIdx];
        end
    end

endmodule

// File: tb/tb_mem_access_stage_p.sv
// Bench for mem_access_stage_p: zero-wait table vectors on one instance,
// hand sequences for wait states, stop and debug on a MEM_LAT=2 instance.
module tb_mem_access_stage_p;

    logic        clk;
    logic        rst;
    logic [4:0]  in_wb;
    logic        in_rd;
    logic        in_wr;
    logic [1:0]  in_size;
    logic        in_uns;
    logic [31:0] in_addr;
    logic [31:0] in_wdata;
    logic [4:0]  in_wreg;
    logic        stop_debug;
    logic        dbg_on;
    logic [31:0] dbg_addr;

    logic        stall0, mis0, stall2, mis2;
    logic [4:0]  wb0, wreg0, wb2, wreg2;
    logic [31:0] rdata0, alu0, dbg0, rdata2, alu2, dbg2;

    int total = 0;
    int bad = 0;

    mem_access_stage_p #(.MEM_LAT(0)) dut0 (
        .clk(clk), .rst(rst), .in_wb(in_wb), .in_rd(in_rd),
        .in_wr(in_wr), .in_size(in_size), .in_uns(in_uns),
        .in_addr(in_addr), .in_wdata(in_wdata), .in_wreg(in_wreg),
        .stop_debug(stop_debug), .dbg_on(dbg_on), .dbg_addr(dbg_addr),
        .stall(stall0), .misalign(mis0), .out_wb(wb0),
        .out_rdata(rdata0), .out_alu(alu0), .out_wreg(wreg0),
        .out_dbg(dbg0)
    );

    mem_access_stage_p #(.MEM_LAT(2)) dut2 (
        .clk(clk), .rst(rst), .in_wb(in_wb), .in_rd(in_rd),
        .in_wr(in_wr), .in_size(in_size), .in_uns(in_uns),
        .in_addr(in_addr), .in_wdata(in_wdata), .in_wreg(in_wreg),
        .stop_debug(stop_debug), .dbg_on(dbg_on), .dbg_addr(dbg_addr),
        .stall(stall2), .misalign(mis2), .out_wb(wb2),
        .out_rdata(rdata2), .out_alu(alu2), .out_wreg(wreg2),
        .out_dbg(dbg2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  wb;
        logic [31:0] expRd;
        logic [4:0]  expWb;
        logic        expMis;
    } vec_t;

    vec_t tbl [20];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic setIn(input logic rd, input logic wr,
                         input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [4:0] wb);
        in_rd = rd; in_wr = wr; in_size = sz; in_uns = uns;
        in_addr = a; in_wdata = wd; in_wb = wb;
    endtask

    task automatic idle();
        in_rd = 1'b0;
        in_wr = 1'b0;
    endtask

    task automatic run2(input logic rd, input logic wr,
                        input logic [1:0] sz, input logic [31:0] a,
                        input logic [31:0] wd, input logic [4:0] wb,
                        input string nm);
        logic s;
        int cyc;
        cyc = 0;
        setIn(rd, wr, sz, 1'b0, a, wd, wb);
        #1;
        for (int k = 0; k < 16; k++) begin
            s = stall2;
            step();
            cyc++;
            if (!s) break;
        end
        chk({nm, "_cycles"}, 32'(cyc), 32'd3);
        chk({nm, "_wb"}, 32'(wb2), 32'(wb));
        idle();
    endtask

    initial begin
        tbl[0]  = '{0, 1, 2'b10, 0, 32'h0,    32'hAABBCCDD, 5'h11, 32'h00000000, 5'h11, 0};
        tbl[1]  = '{0, 1, 2'b00, 0, 32'h3,    32'h00000080, 5'h12, 32'h00000000, 5'h12, 0};
        tbl[2]  = '{1, 0, 2'b00, 0, 32'h3,    32'h0,        5'h13, 32'hFFFFFF80, 5'h13, 0};
        tbl[3]  = '{1, 0, 2'b00, 1, 32'h3,    32'h0,        5'h14, 32'h00000080, 5'h14, 0};
        tbl[4]  = '{1, 0, 2'b10, 0, 32'h0,    32'h0,        5'h15, 32'h80BBCCDD, 5'h15, 0};
        tbl[5]  = '{0, 1, 2'b10, 0, 32'h8,    32'h12345678, 5'h16, 32'h80BBCCDD, 5'h16, 0};
        tbl[6]  = '{1, 0, 2'b01, 0, 32'hA,    32'h0,        5'h17, 32'h00001234, 5'h17, 0};
        tbl[7]  = '{1, 0, 2'b01, 1, 32'h8,    32'h0,        5'h18, 32'h00005678, 5'h18, 0};
        tbl[8]  = '{1, 0, 2'b10, 0, 32'h8,    32'h0,        5'h19, 32'h12345678, 5'h19, 0};
        tbl[9]  = '{1, 0, 2'b01, 0, 32'h2,    32'h0,        5'h1A, 32'hFFFF80BB, 5'h1A, 0};
        tbl[10] = '{1, 0, 2'b00, 1, 32'h1,    32'h0,        5'h1B, 32'h000000CC, 5'h1B, 0};
        tbl[11] = '{1, 0, 2'b10, 0, 32'h6,    32'h0,        5'h1C, 32'h000000CC, 5'h00, 1};
        tbl[12] = '{0, 1, 2'b01, 0, 32'h1,    32'h0000FFFF, 5'h1D, 32'h000000CC, 5'h00, 1};
        tbl[13] = '{1, 0, 2'b10, 0, 32'h0,    32'h0,        5'h1E, 32'h80BBCCDD, 5'h1E, 0};
        tbl[14] = '{0, 0, 2'b10, 0, 32'h44,   32'h0,        5'h07, 32'h80BBCCDD, 5'h07, 0};
        tbl[15] = '{1, 0, 2'b11, 0, 32'h8,    32'h0,        5'h08, 32'h12345678, 5'h08, 0};
        tbl[16] = '{1, 1, 2'b00, 0, 32'h9,    32'h00000055, 5'h09, 32'h12345678, 5'h09, 0};
        tbl[17] = '{1, 0, 2'b10, 0, 32'h8,    32'h0,        5'h0A, 32'h12345578, 5'h0A, 0};
        tbl[18] = '{1, 0, 2'b10, 0, 32'h1000, 32'h0,        5'h0B, 32'h80BBCCDD, 5'h0B, 0};
        tbl[19] = '{1, 0, 2'b00, 0, 32'h2,    32'h0,        5'h0C, 32'hFFFFFFBB, 5'h0C, 0};

        rst = 1'b0; stop_debug = 1'b0; dbg_on = 1'b0; dbg_addr = '0;
        in_wreg = '0;
        setIn(0, 0, 2'b00, 0, 32'h0, 32'h0, 5'h0);
        #3;
        chk("rst0_wb", 32'(wb0), 32'h0);
        chk("rst0_rdata", rdata0, 32'h0);
        chk("rst0_alu", alu0, 32'h0);
        chk("rst0_mis", 32'(mis0), 32'h0);
        chk("rst2_stall", 32'(stall2), 32'h0);
        #1 rst = 1'b1;
        step();

        for (int i = 0; i < 20; i++) begin
            setIn(tbl[i].rd, tbl[i].wr, tbl[i].size, tbl[i].uns,
                  tbl[i].addr, tbl[i].wdata, tbl[i].wb);
            in_wreg = 5'(i);
            #1;
            chk($sformatf("v%0d_stall", i), 32'(stall0), 32'h0);
            step();
            chk($sformatf("v%0d_rdata", i), rdata0, tbl[i].expRd);
            chk($sformatf("v%0d_wb", i), 32'(wb0), 32'(tbl[i].expWb));
            chk($sformatf("v%0d_mis", i), 32'(mis0), 32'(tbl[i].expMis));
            chk($sformatf("v%0d_alu", i), alu0, tbl[i].addr);
            chk($sformatf("v%0d_wreg", i), 32'(wreg0), 32'(i));
        end

        setIn(1, 0, 2'b10, 0, 32'h0, 32'h0, 5'h1F);
        step();
        #2 rst = 1'b0;
        idle();
        #1;
        chk("arst2_wb", 32'(wb2), 32'h0);
        chk("arst2_rdata", rdata2, 32'h0);
        chk("arst2_alu", alu2, 32'h0);
        chk("arst2_wreg", 32'(wreg2), 32'h0);
        chk("arst2_mis", 32'(mis2), 32'h0);
        chk("arst2_dbg", dbg2, 32'h0);
        chk("arst2_stall", 32'(stall2), 32'h0);
        chk("arst0_rdata", rdata0, 32'h0);
        chk("arst0_wb", 32'(wb0), 32'h0);
        #2 rst = 1'b1;
        step();

        run2(0, 1, 2'b10, 32'h0, 32'hCAFEF00D, 5'h01, "sw0");
        run2(0, 1, 2'b10, 32'h8, 32'h12345678, 5'h02, "sw8");

        setIn(1, 0, 2'b10, 0, 32'h8, 32'h0, 5'h15);
        in_wreg = 5'd7;
        #1;
        chk("lat_stall_a", 32'(stall2), 32'h1);
        step();
        chk("lat_e1_wb", 32'(wb2), 32'h0);
        chk("lat_e1_stall", 32'(stall2), 32'h1);
        step();
        chk("lat_e2_wb", 32'(wb2), 32'h0);
        chk("lat_e2_stall", 32'(stall2), 32'h0);
        step();
        chk("lat_e3_wb", 32'(wb2), 32'h15);
        chk("lat_e3_rdata", rdata2, 32'h12345678);
        chk("lat_e3_wreg", 32'(wreg2), 32'd7);
        run2(1, 0, 2'b10, 32'h8, 32'h0, 5'h03, "b2b_lw8");
        chk("b2b_lw8_rdata", rdata2, 32'h12345678);
        run2(1, 0, 2'b10, 32'h0, 32'h0, 5'h04, "b2b_lw0");
        chk("b2b_lw0_rdata", rdata2, 32'hCAFEF00D);

        setIn(1, 0, 2'b10, 0, 32'h6, 32'h0, 5'h1C);
        #1;
        chk("mis_lw_stall", 32'(stall2), 32'h0);
        step();
        chk("mis_lw_pulse", 32'(mis2), 32'h1);
        chk("mis_lw_wb", 32'(wb2), 32'h0);
        setIn(0, 1, 2'b01, 0, 32'h1, 32'h0000FFFF, 5'h1D);
        #1;
        chk("mis_sh_stall", 32'(stall2), 32'h0);
        step();
        chk("mis_sh_pulse", 32'(mis2), 32'h1);
        setIn(0, 0, 2'b10, 0, 32'h0, 32'h0, 5'h05);
        step();
        chk("mis_clear", 32'(mis2), 32'h0);
        chk("mis_clear_wb", 32'(wb2), 32'h05);
        run2(1, 0, 2'b10, 32'h0, 32'h0, 5'h06, "mis_chk");
        chk("mis_mem_kept", rdata2, 32'hCAFEF00D);

        setIn(1, 0, 2'b10, 0, 32'h8, 32'h0, 5'h09);
        #1;
        step();
        stop_debug = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("stop%0d_stall", k), 32'(stall2), 32'h1);
            chk($sformatf("stop%0d_wb", k), 32'(wb2), 32'h0);
            chk($sformatf("stop%0d_rdata", k), rdata2, 32'hCAFEF00D);
        end
        stop_debug = 1'b0;
        step();
        chk("resume_stall", 32'(stall2), 32'h0);
        chk("resume_wb", 32'(wb2), 32'h0);
        step();
        chk("resume_done_wb", 32'(wb2), 32'h09);
        chk("resume_rdata", rdata2, 32'h12345678);

        setIn(1, 0, 2'b10, 0, 32'h0, 32'h0, 5'h0E);
        #1;
        step();
        dbg_on = 1'b1;
        dbg_addr = 32'h8;
        #1;
        chk("dbgw_stall", 32'(stall2), 32'h1);
        step();
        chk("dbgw_e2_stall", 32'(stall2), 32'h0);
        chk("dbgw_e2_wb", 32'(wb2), 32'h0);
        step();
        chk("dbgw_done_wb", 32'(wb2), 32'h0E);
        chk("dbgw_rdata", rdata2, 32'hCAFEF00D);
        chk("dbgw_dbg", dbg2, 32'h12345678);

        setIn(0, 1, 2'b10, 0, 32'h8, 32'hDEADBEEF, 5'h1F);
        #1;
        chk("dbg_stall", 32'(stall2), 32'h0);
        step();
        chk("dbg_wb", 32'(wb2), 32'h0);
        chk("dbg_alu", alu2, 32'h8);
        chk("dbg_word8", dbg2, 32'h12345678);
        step();
        chk("dbg_nowrite", dbg2, 32'h12345678);
        dbg_addr = 32'h0;
        step();
        chk("dbg_word0", dbg2, 32'hCAFEF00D);
        dbg_on = 1'b0;
        idle();
        run2(1, 0, 2'b10, 32'h8, 32'h0, 5'h0D, "post_dbg");
        chk("post_dbg_rdata", rdata2, 32'h12345678);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
